// File: rtl/div32_restoring.sv
// Unsigned restoring divider, one trial subtraction per cycle: WIDTH cycles accept-to-result, 0 extra for divide-by-zero.
// One op in flight; in_ready low from accept until the result is taken with out_ready, result held stable meanwhile.
module div32_restoring #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q, state_d;
    // Partial remainder: the WIDTH+1 bit of the running remainder is always
    // zero after an iteration (pr <= d_reg), so only WIDTH bits are stored.
    logic [WIDTH-1:0] pr_q, pr_d;
    logic [WIDTH-1:0] qr_q, qr_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   s;
    logic [WIDTH:0]   t;
    logic [WIDTH-1:0] pr_nxt;
    logic [WIDTH-1:0] qr_nxt;

    assign s      = {pr_q, qr_q[WIDTH-1]};
    assign t      = s - {1'b0, d_q};
    assign pr_nxt = t[WIDTH] ? s[WIDTH-1:0] : t[WIDTH-1:0];
    assign qr_nxt = {qr_q[WIDTH-2:0], ~t[WIDTH]};

    always_comb begin
        state_d = state_q;
        pr_d    = pr_q;
        qr_d    = qr_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (divisor != '0) begin
                        qr_d    = dividend;
                        pr_d    = '0;
                        d_d     = divisor;
                        cnt_d   = CW'(WIDTH);
                        dbz_d   = 1'b0;
                        state_d = BUSY;
                    end else begin
                        quo_d   = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            BUSY: begin
                pr_d  = pr_nxt;
                qr_d  = qr_nxt;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    quo_d   = qr_nxt;
                    rem_d   = pr_nxt;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pr_q    <= '0;
            qr_q    <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pr_q    <= pr_d;
            qr_q    <= qr_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_div32_restoring.sv
// Directed-vector and constrained-random bench for div32_restoring (WIDTH = 32).
module tb_div32_restoring;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    div32_restoring #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Inputs are driven and outputs sampled 1ns after each rising edge.
    // Latency = rising edges after the accept edge until out_valid is seen:
    // WIDTH for a real division, 0 for divide-by-zero (DONE is entered on
    // the accept edge, so the result is presented in the very next cycle).
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er, input logic ez,
                          input int pre, input int stall, input string nm);
        int          lat;
        bit          busy_ok;
        bit          stable_ok;
        logic [31:0] hq;
        logic [31:0] hr;
        logic        hz;
        repeat (pre) @(posedge clk);
        #1;
        chk({nm, ".in_ready_idle"}, {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        lat      = 0;
        busy_ok  = 1'b1;
        while (!out_valid && lat < 40) begin
            if (in_ready) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        chk({nm, ".latency"}, 64'(lat), ez ? 64'd0 : 64'd32);
        if (!ez) chk({nm, ".in_ready_busy"}, {63'd0, busy_ok}, 64'd1);
        chk({nm, ".quotient"}, {32'd0, quotient}, {32'd0, eq});
        chk({nm, ".remainder"}, {32'd0, remainder}, {32'd0, er});
        chk({nm, ".div_by_zero"}, {63'd0, div_by_zero}, {63'd0, ez});
        hq = quotient;
        hr = remainder;
        hz = div_by_zero;
        stable_ok = 1'b1;
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            dividend = $urandom;
            divisor  = $urandom;
            @(posedge clk);
            #1;
            if (!out_valid || in_ready || quotient !== hq || remainder !== hr || div_by_zero !== hz)
                stable_ok = 1'b0;
        end
        in_valid = 1'b0;
        if (stall > 0) chk({nm, ".held"}, {63'd0, stable_ok}, 64'd1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({nm, ".released"}, {62'd0, in_ready, out_valid}, 64'b10);
    endtask

    initial begin
        logic [31:0] ra, rb;
        bit          saw_valid;

        vecs[0] = '{32'd100,        32'd7,          32'd14,         32'd2, 1'b0};
        vecs[1] = '{32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0, 1'b0};
        vecs[2] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0, 1'b0};
        vecs[3] = '{32'd3,          32'hFFFFFFFF,   32'd0,          32'd3, 1'b0};
        vecs[4] = '{32'h80000000,   32'h00010000,   32'h00008000,   32'd0, 1'b0};
        vecs[5] = '{32'd0,          32'd5,          32'd0,          32'd0, 1'b0};
        vecs[6] = '{32'd5,          32'd0,          32'hFFFFFFFF,   32'd5, 1'b1};
        vecs[7] = '{32'd9,          32'd3,          32'd3,          32'd0, 1'b0};
        vecs[8] = '{32'd1000,       32'd3,          32'd333,        32'd1, 1'b0};

        #2;
        chk("reset.outputs", {quotient, remainder}, 64'd0);
        chk("reset.flags", {61'd0, div_by_zero, out_valid, in_ready}, 64'b001);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        foreach (vecs[i])
            run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z, 0, 0, $sformatf("vec%0d", i));

        run_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1, 10, "backpressure");
        run_op(32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1, 0, 3, "dbz_backpressure");

        // Abort an operation 10 cycles into BUSY.
        in_valid = 1'b1;
        dividend = 32'd1000;
        divisor  = 32'd3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midreset.outputs", {quotient, remainder}, 64'd0);
        chk("midreset.flags", {61'd0, div_by_zero, out_valid, in_ready}, 64'b001);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n = 1'b1;
        saw_valid = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) saw_valid = 1'b1;
        end
        chk("midreset.no_result", {63'd0, saw_valid}, 64'd0);
        run_op(32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 0, 0, "after_reset");

        for (int n = 0; n < 300; n++) begin
            ra = $urandom >> $urandom_range(0, 31);
            rb = ($urandom_range(0, 19) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
            if (rb == 32'd0)
                run_op(ra, rb, 32'hFFFFFFFF, ra, 1'b1, $urandom_range(0, 3), $urandom_range(0, 3),
                       $sformatf("rnd%0d", n));
            else
                run_op(ra, rb, ra / rb, ra % rb, 1'b0, $urandom_range(0, 3), $urandom_range(0, 3),
                       $sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
